// File: rtl/hamming15_pkg.sv
// hamming15_pkg: shared constants, FSM state type and the Hamming(15,11)
// encoder used by the hamming15_sched codeword scheduler.
//   DATA_W  - data word width (in1..in11 at bits 0..10)
//   CODE_W  - codeword width (position k at bit k-1)
//   POS_W   - width of a codeword position index (0 = none)
package hamming15_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int POS_W  = 4;

  // Parity positions (1-based codeword positions)
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Data bits go to the non-power-of-two positions 3,5,6,7,9..15; each parity
  // bit covers the positions whose index has that parity's bit set.
  function automatic logic [CODE_W-1:0] hamming15_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[2]      = d[0];
    c[4]      = d[1];
    c[5]      = d[2];
    c[6]      = d[3];
    c[14:8]   = d[10:4];
    c[P1_POS-1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    c[P2_POS-1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    c[P4_POS-1] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    c[P8_POS-1] = ^d[10:4];
    return c;
  endfunction

endpackage

// File: rtl/hamming15_rr_arb.sv
// hamming15_rr_arb: combinational round-robin arbiter.
// Grants the first asserted request at or after ptr, wrapping NREQ-1 -> 0.
//   req   in  NREQ  request vector
//   ptr   in  SRCW  highest-priority index this cycle
//   en    in  1     grant enable; when low grant is all zero
//   grant out NREQ  one-hot grant or zero
//   idx   out SRCW  index of granted request (0 when none)
module hamming15_rr_arb
  import hamming15_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [SRCW-1:0] idx
);

  logic [SRCW:0] pos;
  logic          found;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One spare bit holds ptr+k before the wrap back into 0..NREQ-1.
      pos = {1'b0, ptr} + (SRCW+1)'(k);
      if (pos >= (SRCW+1)'(NREQ)) pos = pos - (SRCW+1)'(NREQ);
      if (en && !found && req[pos[SRCW-1:0]]) begin
        found                = 1'b1;
        grant[pos[SRCW-1:0]] = 1'b1;
        idx                  = pos[SRCW-1:0];
      end
    end
  end

endmodule

// File: rtl/hamming15_sched.sv
// hamming15_sched: round-robin scheduler sharing one Hamming(15,11) encode
// stage between NREQ requesters, with a registered one-entry output.
// Optional feature macro: HAMMING15_ERR_SEQ_EN enables the sequenced
// single-bit error injector (err_en / out_errpos); without it err_en is
// ignored and out_errpos is tied 0.
//   clock, reset_n        clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; word i at req_data[11*i +: 11]
//   err_en                enable error sequencing, sampled at accept
//   out_valid/out_ready   output handshake
//   out_code              15-bit codeword, bit k-1 = position k
//   out_src               requester index of the held codeword
//   out_errpos            flipped position, 0 = none
module hamming15_sched
  import hamming15_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   err_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODE_W-1:0]      out_code,
  output logic [SRCW-1:0]        out_src,
  output logic [POS_W-1:0]       out_errpos
);

  state_t            state, state_next;
  logic [SRCW-1:0]   rr_ptr;
  logic [SRCW-1:0]   grant_idx;
  logic              can_load;
  logic              arb_en;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] code_next;

  // The slot can take a word when empty or when the held word leaves this
  // cycle. Gating with reset_n keeps req_ready low for the whole reset.
  assign can_load = (state == ST_EMPTY) || out_ready;
  assign arb_en   = can_load && reset_n;

  hamming15_rr_arb #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (req_ready),
    .idx   (grant_idx)
  );

  assign accept   = |req_ready;
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];
  assign enc_code = hamming15_encode(sel_data);

  // Output FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_next;
  end

  // Output FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Output FSM: outputs
  always_comb begin
    out_valid = (state == ST_FULL);
  end

  // Output register and round-robin pointer. A stall (FULL, !out_ready)
  // blocks accept, so everything here simply holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_code <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      out_code <= code_next;
      out_src  <= grant_idx;
      rr_ptr   <= (grant_idx == SRCW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef HAMMING15_ERR_SEQ_EN
  logic [POS_W-1:0]  err_cnt;
  logic [CODE_W-1:0] flip_mask;

  // err_cnt is a 1-based position; 0 means this word goes out clean.
  always_comb begin
    flip_mask = '0;
    if (err_en && err_cnt != '0) flip_mask[err_cnt - 1'b1] = 1'b1;
  end

  assign code_next = enc_code ^ flip_mask;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt    <= '0;
      out_errpos <= '0;
    end else if (accept) begin
      if (err_en) begin
        out_errpos <= err_cnt;
        err_cnt    <= err_cnt + 1'b1;
      end else begin
        out_errpos <= '0;
      end
    end
  end
`else
  logic unused_err_en;
  assign unused_err_en = err_en;
  assign code_next     = enc_code;
  assign out_errpos    = '0;
`endif

endmodule
